// File: rtl/store_buffer.sv
// Purpose : memory-stage store buffer. A circular FIFO of committed stores that drains to the
//           data cache in order; loads are checked against every buffered entry at word granularity.
// Latency : a store is offered on o_mem_* the cycle after it enqueues and is popped on the edge
//           where o_mem_valid & i_mem_ready.
// Backpressure: o_stall is raised for a store while the buffer is full (a same-cycle pop does not
//           relieve it), and for a matching load when forwarding is not built in.
// Build option: define STORE_BUFFER_FWD_EN to forward load data from the youngest matching entry.
//           Without it, a matching load stalls until every matching entry has drained.
// Ports   : clk/rst_n (async active-low); i_valid/i_mem_action/i_addr/i_data/i_stall/i_flush =
//           memory-stage op; o_stall = request to hazard control; o_fwd_hit/o_fwd_data = forwarding;
//           o_mem_valid/o_mem_addr/o_mem_data/i_mem_ready = drain to the cache; o_count = occupancy.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic                     i_mem_action,
    input  logic [ADDR_WIDTH-1:0]    i_addr,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic                     o_fwd_hit,
    output logic [DATA_WIDTH-1:0]    o_fwd_data,
    output logic                     o_mem_valid,
    output logic [ADDR_WIDTH-1:0]    o_mem_addr,
    output logic [DATA_WIDTH-1:0]    o_mem_data,
    input  logic                     i_mem_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_write;
    logic                  w_load;
    logic                  w_full;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_match_data;
    logic                  w_hit;

    assign w_write     = i_valid & i_mem_action & ~i_flush;
    assign w_load      = i_valid & ~i_mem_action & ~i_flush;
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_not_empty = (r_count != '0);
    // Full is judged on the registered count only, so a pop in the same cycle never lets a
    // store in; it enters the cycle after the slot has actually been freed.
    assign w_push      = w_write & ~i_stall & ~w_full;
    assign w_pop       = w_not_empty & i_mem_ready;

    // Walk entries oldest to youngest; the last hit wins, giving the youngest matching store.
    // The head is included even if it is being popped this cycle.
    always_comb begin
        w_match      = 1'b0;
        w_match_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) && r_vld[r_head + PTR_W'(k)] &&
                (r_addr[r_head + PTR_W'(k)][ADDR_WIDTH-1:2] == i_addr[ADDR_WIDTH-1:2])) begin
                w_match      = 1'b1;
                w_match_data = r_data[r_head + PTR_W'(k)];
            end
        end
    end

    assign w_hit = w_load & w_match;

`ifdef STORE_BUFFER_FWD_EN
    assign o_fwd_hit  = w_hit;
    assign o_fwd_data = w_hit ? w_match_data : '0;
    assign o_stall    = w_write & w_full;
`else
    assign o_fwd_hit  = 1'b0;
    assign o_fwd_data = '0;
    assign o_stall    = (w_write & w_full) | w_hit;
`endif

    // Head fields are gated by occupancy so they read zero while empty or held in reset.
    assign o_mem_valid = w_not_empty;
    assign o_mem_addr  = w_not_empty ? r_addr[r_head] : '0;
    assign o_mem_data  = w_not_empty ? r_data[r_head] : '0;
    assign o_count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed through valid, occupied entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_mem_action, i_stall, i_flush, i_mem_ready;
    logic [31:0] i_addr, i_data;
    logic        o_stall, o_fwd_hit, o_mem_valid;
    logic [31:0] o_fwd_data, o_mem_addr, o_mem_data;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_mem_action(i_mem_action), .i_addr(i_addr), .i_data(i_data),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_stall(o_stall), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data),
        .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .i_mem_ready(i_mem_ready), .o_count(o_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        i_valid = 1'b1; i_mem_action = 1'b1; i_addr = a; i_data = d;
    endtask

    task automatic drive_idle();
        i_valid = 1'b0; i_mem_action = 1'b0; i_addr = '0; i_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive_idle(); i_stall = 0; i_flush = 0; i_mem_ready = 0;
        @(negedge clk);
        // A load while in reset must not see anything.
        i_valid = 1'b1; i_mem_action = 1'b0; i_addr = 32'h100;
        #1;
        n_checks++; if (o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got=%b exp=0", o_mem_valid); end
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        n_checks++; if (o_fwd_hit !== 1'b0 || o_fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_fwd got=%b/%h exp=0/0", o_fwd_hit, o_fwd_data); end
        n_checks++; if (o_mem_addr !== 32'h0 || o_mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", o_mem_addr, o_mem_data); end
        drive_idle();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single_store();
        @(negedge clk);
        i_mem_ready = 1'b1; drive_store(32'h100, 32'hAAAA);
        #1;
        n_checks++; if (o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid got=%b exp=0", o_mem_valid); end
        @(negedge clk); drive_idle(); #1;
        n_checks++; if (o_mem_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", o_mem_valid); end
        n_checks++; if (o_mem_addr !== 32'h100 || o_mem_data !== 32'hAAAA) begin n_fail++; $display("FAIL single_head got=%h/%h exp=100/aaaa", o_mem_addr, o_mem_data); end
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_count1 got=%0d exp=1", o_count); end
        @(negedge clk); #1;
        n_checks++; if (o_count !== 3'd0 || o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%0d/%b exp=0/0", o_count, o_mem_valid); end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_full();
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive_store(32'h300 + 32'(4*k), 32'h50 + 32'(k));
        end
        @(negedge clk);
        drive_store(32'h310, 32'h54); #1;
        n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", o_count); end
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", o_stall); end
        @(negedge clk); i_mem_ready = 1'b1; #1;
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall_with_pop got=%b exp=1", o_stall); end
        @(negedge clk); i_mem_ready = 1'b0; #1;
        n_checks++; if (o_count !== 3'd3 || o_stall !== 1'b0) begin n_fail++; $display("FAIL full_after_pop got=%0d/%b exp=3/0", o_count, o_stall); end
        @(negedge clk); drive_idle(); #1;
        n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_in got=%0d exp=4", o_count); end
        i_mem_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            n_checks++; if (o_mem_addr !== 32'h300 + 32'(4*k) || o_mem_data !== 32'h50 + 32'(k)) begin n_fail++; $display("FAIL full_drain%0d got=%h/%h exp=%h/%h", k, o_mem_addr, o_mem_data, 32'h300 + 32'(4*k), 32'h50 + 32'(k)); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL full_empty got=%0d exp=0", o_count); end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_load_match();
        @(negedge clk); drive_store(32'h200, 32'h11);
        @(negedge clk); drive_store(32'h200, 32'h22);
        @(negedge clk);
        i_valid = 1'b1; i_mem_action = 1'b0; i_addr = 32'h210; i_data = 32'hDEAD; #1;
        n_checks++; if (o_stall !== 1'b0 || o_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL ld_nomatch got=%b/%b exp=0/0", o_stall, o_fwd_hit); end
        i_addr = 32'h202; i_flush = 1'b1; #1;
        n_checks++; if (o_stall !== 1'b0 || o_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL ld_flushed got=%b/%b exp=0/0", o_stall, o_fwd_hit); end
        i_flush = 1'b0; #1;
`ifdef STORE_BUFFER_FWD_EN
        n_checks++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h22 || o_stall !== 1'b0) begin n_fail++; $display("FAIL ld_fwd got=%b/%h/%b exp=1/22/0", o_fwd_hit, o_fwd_data, o_stall); end
`else
        n_checks++; if (o_stall !== 1'b1 || o_fwd_hit !== 1'b0 || o_fwd_data !== 32'h0) begin n_fail++; $display("FAIL ld_stall got=%b/%b/%h exp=1/0/0", o_stall, o_fwd_hit, o_fwd_data); end
`endif
        i_mem_ready = 1'b1;
        @(negedge clk); i_mem_ready = 1'b0; #1;
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL ld_one_left got=%0d exp=1", o_count); end
`ifdef STORE_BUFFER_FWD_EN
        n_checks++; if (o_fwd_hit !== 1'b1 || o_fwd_data !== 32'h22) begin n_fail++; $display("FAIL ld_fwd_one_left got=%b/%h exp=1/22", o_fwd_hit, o_fwd_data); end
`else
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_one_left got=%b exp=1", o_stall); end
`endif
        i_mem_ready = 1'b1;
        @(negedge clk); i_mem_ready = 1'b0; #1;
        n_checks++; if (o_stall !== 1'b0 || o_fwd_hit !== 1'b0 || o_fwd_data !== 32'h0) begin n_fail++; $display("FAIL ld_drained got=%b/%b/%h exp=0/0/0", o_stall, o_fwd_hit, o_fwd_data); end
        drive_idle();
    endtask

    task automatic test_flush_stall();
        @(negedge clk); drive_store(32'h500, 32'h77); i_flush = 1'b1;
        @(negedge clk); i_flush = 1'b0; drive_idle(); #1;
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        drive_store(32'h504, 32'h78); i_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL stall_hold%0d got=%0d exp=0", k, o_count); end
        end
        i_stall = 1'b0;
        @(negedge clk); drive_idle(); #1;
        n_checks++; if (o_count !== 3'd1 || o_mem_addr !== 32'h504 || o_mem_data !== 32'h78) begin n_fail++; $display("FAIL stall_release got=%0d/%h/%h exp=1/504/78", o_count, o_mem_addr, o_mem_data); end
        i_mem_ready = 1'b1;
        @(negedge clk); i_mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        i_mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 9) drive_store(32'h400 + 32'(4*k), 32'h1000 + 32'(k));
            else drive_idle();
            #1;
            if (k > 0) begin
                n_checks++; if (o_count !== 3'd1 || o_mem_addr !== 32'h400 + 32'(4*(k-1)) || o_mem_data !== 32'h1000 + 32'(k-1)) begin n_fail++; $display("FAIL wrap%0d got=%0d/%h/%h exp=1/%h/%h", k, o_count, o_mem_addr, o_mem_data, 32'h400 + 32'(4*(k-1)), 32'h1000 + 32'(k-1)); end
            end
        end
        @(negedge clk); #1;
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty got=%0d exp=0", o_count); end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive_store(32'h600 + 32'(4*k), 32'h9 + 32'(k));
        end
        @(negedge clk); drive_idle(); #1;
        n_checks++; if (o_count !== 3'd3 || o_mem_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%0d/%b exp=3/1", o_count, o_mem_valid); end
        i_mem_ready = 1'b1; rst_n = 1'b0; #1;
        n_checks++; if (o_count !== 3'd0 || o_mem_valid !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_data !== 32'h0) begin n_fail++; $display("FAIL rst_async got=%0d/%b/%h/%h exp=0/0/0/0", o_count, o_mem_valid, o_mem_addr, o_mem_data); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++; if (o_count !== 3'd0 || o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after%0d got=%0d/%b exp=0/0", k, o_count, o_mem_valid); end
        end
        i_mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full();
        test_load_match();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
